// File: rtl/first1_scan.sv
// Streaming set-bit iterator: accepts an occupancy bitmap and emits the index of every
// set bit, one per beat, LSB-first or MSB-first, with ordinal, last and empty flags.
module first1_scan #(
    parameter int unsigned LEN        = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(LEN),
    parameter int unsigned CNT_WIDTH  = $clog2(LEN + 1),
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [LEN-1:0]        in_array,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [CNT_WIDTH-1:0]  out_cnt,
    output logic                  out_last,
    output logic                  out_empty,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                state_q;
    logic [LEN-1:0]        mask_q;
    logic                  empty_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [ADDR_WIDTH-1:0] enc;
    logic                  single;
    logic                  scan;
    logic                  accept;
    logic                  beat;

    // Priority encoder; the loop direction makes the preferred end win.
    always_comb begin
        enc = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(LEN); i++) begin
                if (mask_q[i]) enc = ADDR_WIDTH'(i);
            end
        end else begin
            for (int i = int'(LEN) - 1; i >= 0; i--) begin
                if (mask_q[i]) enc = ADDR_WIDTH'(i);
            end
        end
    end

    assign single    = (mask_q != '0) && ((mask_q & (mask_q - LEN'(1))) == '0);
    assign scan      = (state_q == StScan);

    // Outputs are forced to zero outside SCAN so stale mask/cnt never leak out.
    assign out_vld   = scan;
    assign busy      = scan;
    assign out_addr  = scan ? enc : '0;
    assign out_cnt   = scan ? cnt_q : '0;
    assign out_empty = scan & empty_q;
    assign out_last  = scan & (empty_q | single);

    assign in_rdy    = !rst && !clear && (!scan || (out_last && out_rdy));
    assign accept    = in_vld & in_rdy;
    assign beat      = out_vld & out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            empty_q <= 1'b0;
            cnt_q   <= '0;
        end else if (clear) begin
            state_q <= StIdle;
            mask_q  <= '0;
            empty_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            // Also covers the reload in the last-beat cycle of the previous array.
            state_q <= StScan;
            mask_q  <= in_array;
            empty_q <= (in_array == '0);
            cnt_q   <= '0;
        end else if (beat) begin
            if (out_last) begin
                state_q <= StIdle;
            end else begin
                mask_q <= mask_q & ~(LEN'(1) << enc);
                cnt_q  <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_first1_scan.sv
// Self-checking bench for first1_scan: LSB-first and MSB-first instances share stimulus,
// a vector table drives whole arrays, and hand sequences cover the multi-cycle corners.
module tb_first1_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_array = 8'h00;
    logic       out_rdy = 1'b1;

    logic       l_in_rdy, l_vld, l_last, l_empty, l_busy;
    logic [2:0] l_addr;
    logic [3:0] l_cnt;
    logic       m_in_rdy, m_vld, m_last, m_empty, m_busy;
    logic [2:0] m_addr;
    logic [3:0] m_cnt;

    int total = 0;
    int bad = 0;

    first1_scan #(.LEN(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .clear(clear), .in_vld(in_vld), .in_rdy(l_in_rdy),
        .in_array(in_array), .out_vld(l_vld), .out_rdy(out_rdy), .out_addr(l_addr),
        .out_cnt(l_cnt), .out_last(l_last), .out_empty(l_empty), .busy(l_busy)
    );

    first1_scan #(.LEN(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .clear(clear), .in_vld(in_vld), .in_rdy(m_in_rdy),
        .in_array(in_array), .out_vld(m_vld), .out_rdy(out_rdy), .out_addr(m_addr),
        .out_cnt(m_cnt), .out_last(m_last), .out_empty(m_empty), .busy(m_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_l_vld"}, 32'(l_vld), 0);
        check({tag, "_l_busy"}, 32'(l_busy), 0);
        check({tag, "_m_vld"}, 32'(m_vld), 0);
        check({tag, "_m_busy"}, 32'(m_busy), 0);
    endtask

    // seq holds the LSB-first index of beat k in nibble k; MSB-first is its reverse.
    // Entered at a negedge with both instances idle; leaves at a negedge, idle.
    task automatic run_array(input string tag, input logic [7:0] arr, input logic [31:0] seq,
                             input int n);
        in_vld = 1'b1;
        in_array = arr;
        out_rdy = 1'b1;
        #1;
        check({tag, "_acc_rdy"}, 32'(l_in_rdy & m_in_rdy), 1);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        in_array = 8'h5A;
        for (int k = 0; k < n; k++) begin
            check({tag, "_l_vld"}, 32'(l_vld), 1);
            check({tag, "_l_addr"}, 32'(l_addr), 32'(seq[4*k +: 3]));
            check({tag, "_l_cnt"}, 32'(l_cnt), 32'(k));
            check({tag, "_l_last"}, 32'(l_last), 32'(k == n - 1));
            check({tag, "_l_empty"}, 32'(l_empty), 32'(arr == 8'h00));
            check({tag, "_l_in_rdy"}, 32'(l_in_rdy), 32'(k == n - 1));
            check({tag, "_m_addr"}, 32'(m_addr), 32'(seq[4*(n-1-k) +: 3]));
            check({tag, "_m_cnt"}, 32'(m_cnt), 32'(k));
            check({tag, "_m_last"}, 32'(m_last), 32'(k == n - 1));
            @(negedge clk);
        end
        check_idle({tag, "_end"});
    endtask

    typedef struct {
        logic [7:0]  arr;
        logic [31:0] seq;
        int          n;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] p_addr;
        logic [3:0] p_cnt;
        logic       stalled;
        logic       go;
        int         k;

        tbl[0] = '{arr: 8'hA6, seq: 32'h0000_7521, n: 4};
        tbl[1] = '{arr: 8'h00, seq: 32'h0000_0000, n: 1};
        tbl[2] = '{arr: 8'hFF, seq: 32'h7654_3210, n: 8};
        tbl[3] = '{arr: 8'h10, seq: 32'h0000_0004, n: 1};
        tbl[4] = '{arr: 8'h81, seq: 32'h0000_0070, n: 2};
        tbl[5] = '{arr: 8'h3C, seq: 32'h0000_5432, n: 4};

        // Reset state
        #2;
        check("rst_in_rdy_l", 32'(l_in_rdy), 0);
        check("rst_in_rdy_m", 32'(m_in_rdy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_rdy", 32'(l_in_rdy), 1);
        check("rel_addr", 32'(l_addr), 0);
        check("rel_cnt", 32'(l_cnt), 0);
        check("rel_last", 32'(l_last), 0);
        check("rel_empty", 32'(l_empty), 0);
        check_idle("rel");
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_array($sformatf("vec%0d", i), tbl[i].arr, tbl[i].seq, tbl[i].n);
        end

        // Back-to-back 81 then FF; second accept lands on the addr-7 last beat
        in_vld = 1'b1;
        in_array = 8'h81;
        out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_array = 8'hFF;
        check("b2b_a0_addr", 32'(l_addr), 0);
        check("b2b_a0_rdy", 32'(l_in_rdy), 0);
        @(negedge clk);
        check("b2b_a1_addr", 32'(l_addr), 7);
        check("b2b_a1_last", 32'(l_last), 1);
        check("b2b_a1_rdy", 32'(l_in_rdy), 1);
        @(negedge clk);
        in_vld = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("b2b_ff_vld", 32'(l_vld), 1);
            check("b2b_ff_addr", 32'(l_addr), 32'(j));
            check("b2b_ff_cnt", 32'(l_cnt), 32'(j));
            check("b2b_ff_last", 32'(l_last), 32'(j == 7));
            check("b2b_ff_maddr", 32'(m_addr), 32'(7 - j));
            @(negedge clk);
        end
        check_idle("b2b_end");

        // Backpressure on 3C: outputs hold while stalled, no loss or duplication
        in_vld = 1'b1;
        in_array = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        k = 0;
        stalled = 1'b0;
        p_addr = '0;
        p_cnt = '0;
        for (int c = 0; c < 200 && k < 4; c++) begin
            check("bp_vld", 32'(l_vld), 1);
            if (stalled) begin
                check("bp_hold_addr", 32'(l_addr), 32'(p_addr));
                check("bp_hold_cnt", 32'(l_cnt), 32'(p_cnt));
            end
            go = (c == 0 || c == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            out_rdy = go;
            #1;
            if (go) begin
                check("bp_addr", 32'(l_addr), 32'(k + 2));
                check("bp_maddr", 32'(m_addr), 32'(5 - k));
                check("bp_cnt", 32'(l_cnt), 32'(k));
                check("bp_last", 32'(l_last), 32'(k == 3));
                k++;
                stalled = 1'b0;
            end else begin
                check("bp_stall_rdy", 32'(l_in_rdy), 0);
                p_addr = l_addr;
                p_cnt = l_cnt;
                stalled = 1'b1;
            end
            @(negedge clk);
        end
        check("bp_beats", 32'(k), 4);
        out_rdy = 1'b1;
        check_idle("bp_end");

        // clear after the 2nd beat of F0; a concurrent in_vld must not be accepted
        in_vld = 1'b1;
        in_array = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        check("clr_b0", 32'(l_addr), 4);
        @(negedge clk);
        check("clr_b1", 32'(l_addr), 5);
        @(negedge clk);
        clear = 1'b1;
        in_vld = 1'b1;
        in_array = 8'h55;
        #1;
        check("clr_in_rdy", 32'(l_in_rdy), 0);
        @(negedge clk);
        clear = 1'b0;
        in_vld = 1'b0;
        check_idle("clr_after");
        run_array("clr_next", 8'h01, 32'h0, 1);

        // Asynchronous reset mid-scan aborts at once
        in_vld = 1'b1;
        in_array = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        check("rstm_b1", 32'(l_addr), 1);
        rst = 1'b1;
        #1;
        check("rstm_async_vld", 32'(l_vld), 0);
        check("rstm_in_rdy", 32'(l_in_rdy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rstm_rel");
        check("rstm_rel_rdy", 32'(l_in_rdy), 1);
        @(negedge clk);
        check_idle("rstm_rel2");
        run_array("rstm_next", 8'h01, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/first1_scan.md
# first1_scan

Streaming set-bit index iterator: accepts a LEN-bit occupancy array over a valid/ready handshake and emits the index of every set bit, one per cycle, in LSB-first or MSB-first order, with ordinal count, last and empty flags. It is the sequential generalisation of the single-shot first-one priority encoder. It sits between sparse-activation bitmap producers and the address generators of the compute array, converting a sparsity mask into a compact stream of nonzero positions.

## Interface
- LEN, 32, array width in bits; must be ≥2
- ADDR_WIDTH, $clog2(LEN), index width
- CNT_WIDTH, $clog2(LEN+1), ordinal/popcount width
- MSB_FIRST, 0, 0 = emit lowest index first, 1 = highest index first
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort; drops the array in flight
- in_vld  input  1  in_array valid
- in_rdy  output  1  block accepts an array this cycle
- in_array  input  LEN  occupancy bitmap
- out_vld  output  1  out_* valid
- out_rdy  input  1  downstream accepts the beat
- out_addr  output  ADDR_WIDTH  index of the current set bit; 0 on an empty beat
- out_cnt  output  CNT_WIDTH  ordinal of this beat within the array, starting at 0
- out_last  output  1  final beat of the current array
- out_empty  output  1  the array had no set bits; single beat
- busy  output  1  state is SCAN

## Operation
- State IDLE or SCAN. Registers: mask[LEN], empty_f, cnt[CNT_WIDTH].
- in_rdy = !rst & !clear & (IDLE | (SCAN & out_last & out_rdy)). Accepting in the last-beat handshake cycle gives back-to-back arrays without bubbles.
- Accept (in_vld & in_rdy): mask <= in_array, empty_f <= (in_array == 0), cnt <= 0, state <= SCAN.
- In SCAN, out_vld = 1.
  - out_addr = position of the lowest set bit of mask, or the highest set bit when MSB_FIRST = 1.
  - out_cnt = cnt.
  - out_empty = empty_f.
  - out_last = empty_f | (exactly one bit set in mask).
- Beat handshake (out_vld & out_rdy):
  - If the beat is not last: clear mask[out_addr], cnt <= cnt + 1.
  - If the beat is last: state <= IDLE, unless an accept happens in the same cycle, in which case reload per the accept rule.
- Stall: while out_vld & !out_rdy, every out_* holds stable and in_rdy stays 0.
- Empty array: exactly one beat with out_addr = 0, out_cnt = 0, out_last = 1, out_empty = 1.
- Full array (all ones): LEN beats, out_cnt runs 0..LEN-1, out_last only on beat LEN-1. cnt never wraps.
- clear has priority over all other events. Next state is IDLE with mask and cnt zeroed. A beat presented in the same cycle as clear is still counted by downstream if out_rdy = 1. No accept occurs in the clear cycle.
- in_array is sampled only on accept. Changes while not accepted are ignored.

## Timing
- Reset values: state IDLE, mask 0, cnt 0, empty_f 0. Outputs: out_vld 0, out_addr 0, out_cnt 0, out_last 0, out_empty 0, busy 0. in_rdy 0 while rst is high, 1 in the first cycle after release.
- Latency: an array accepted at edge N presents its first beat in the cycle after edge N, i.e. one cycle from accept to out_vld.
- Throughput: an array with P set bits occupies max(P,1) cycles under continuous out_rdy, and the next array is accepted in the last-beat cycle.
- Outputs are derived only from registers. There is no combinational path from in_* to out_*. in_rdy depends combinationally on out_rdy, clear and rst.
- Asynchronous reset mid-scan aborts immediately. No partial beat follows reset release.

## Test plan
- LEN = 8, MSB_FIRST = 0, in_array = 8'b1010_0110, out_rdy = 1 → out_addr 1,2,5,7; out_cnt 0..3; out_last only on addr 7; first out_vld one cycle after accept.
- Same array with MSB_FIRST = 1 → out_addr 7,5,2,1; out_last on addr 1.
- in_array = 0 → one beat: out_empty = 1, out_last = 1, out_addr = 0, out_cnt = 0; back in IDLE the next cycle.
- Back-to-back: 8'h81 then 8'hFF with in_vld held and out_rdy = 1 → 2 + 8 consecutive beats with no bubble. out_cnt for 8'hFF is 0..7. Second accept coincides with the addr-7 last beat of the first array.
- Random out_rdy backpressure on 8'h3C → out_addr/out_cnt hold stable while stalled; sequence 2,3,4,5 with no loss or duplication.
- clear asserted after the 2nd beat of 8'hF0, or rst pulsed mid-scan → next cycle out_vld = 0, busy = 0; the next array 8'h01 yields a single beat addr 0, cnt 0, last 1.
